// File: rtl/motor_oc_pkg.sv
// Shared types and defaults for the motor overcurrent supervisor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package motor_oc_pkg;

   // Supervisor sequencer states.
   typedef enum logic [2:0] {
      RUN     = 3'd0,
      QUAL    = 3'd1,
      TRIP    = 3'd2,
      COOL    = 3'd3,
      LOCKOUT = 3'd4
   } oc_state_t;

   // Commands for the shared qualification / cool-down / healthy-window timer.
   typedef enum logic [2:0] {
      TMR_HOLD = 3'd0,
      TMR_CLR  = 3'd1,
      TMR_LOAD = 3'd2,
      TMR_INC  = 3'd3,
      TMR_DEC  = 3'd4
   } tmr_cmd_t;

   localparam int unsigned QUAL_CYCLES_DEF = 33_554_432;   // ~335 ms at 100 MHz
   localparam int unsigned COOL_CYCLES_DEF = 100_000_000;  // 1 s at 100 MHz
   localparam int unsigned MAX_RETRY_DEF   = 3;
   localparam int unsigned CNT_W_DEF       = 27;
   localparam int unsigned RETRY_W         = 3;

endpackage

// File: rtl/motor_oc_supervisor_if.sv
// Signal bundle between drive logic / sense pins and the overcurrent supervisor.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels except the single-cycle fault_clr pulse.
// Ports: OCA/OCB sense (low = fault), req_a/req_b enable requests, fault_clr pulse,
//        ENA/ENB bridge enables, overcurrent/lockout status, retry_cnt.
//        With OC_CAUSE_EN defined, also oc_cause[1:0] = {B low, A low} at the last trip.
interface motor_oc_supervisor_if;
   import motor_oc_pkg::*;

   logic               OCA;
   logic               OCB;
   logic               req_a;
   logic               req_b;
   logic               fault_clr;
   logic               ENA;
   logic               ENB;
   logic               overcurrent;
   logic               lockout;
   logic [RETRY_W-1:0] retry_cnt;
`ifdef OC_CAUSE_EN
   logic [1:0]         oc_cause;
`endif

   // Drive-logic / board side.
   modport master (
      output OCA, OCB, req_a, req_b, fault_clr,
      input  ENA, ENB, overcurrent, lockout, retry_cnt
`ifdef OC_CAUSE_EN
      , input oc_cause
`endif
   );

   // Supervisor side.
   modport slave (
      input  OCA, OCB, req_a, req_b, fault_clr,
      output ENA, ENB, overcurrent, lockout, retry_cnt
`ifdef OC_CAUSE_EN
      , output oc_cause
`endif
   );

endinterface

// File: rtl/motor_oc_supervisor_timer.sv
// oc_timer: load / clear / increment / decrement / hold counter with a zero flag.
// Latency: count updates on the clock edge after the command; zero_o is combinational from the count.
// Backpressure: none; a command is applied every cycle.
// Ports: clk, rst_n (async active-low), cmd_i, load_val_i, cnt_o, zero_o.
module oc_timer
   import motor_oc_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  tmr_cmd_t         cmd_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      case (cmd_i)
         TMR_CLR:  cnt_d = '0;
         TMR_LOAD: cnt_d = load_val_i;
         TMR_INC:  cnt_d = cnt_q + 1'b1;
         TMR_DEC:  cnt_d = cnt_q - 1'b1;
         default:  cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/motor_oc_supervisor.sv
// Overcurrent protection sequencer: qualifies OCA/OCB, trips enables, cools down, retries, locks out.
// Latency: ENA/ENB follow req_a/req_b one cycle later while healthy; trip after QUAL_CYCLES of sustained fault.
// Backpressure: none; requests are levels, enables are forced low while the bridge is faulted.
// Ports: CLK100MHZ, CPU_RESETN (async active-low), bus (slave modport of motor_oc_supervisor_if).
// Optional OC_CAUSE_EN macro: adds bus.oc_cause, latched on TRIP entry, cleared on lockout exit.
module motor_oc_supervisor
   import motor_oc_pkg::*;
#(
   parameter int unsigned QUAL_CYCLES = QUAL_CYCLES_DEF,
   parameter int unsigned COOL_CYCLES = COOL_CYCLES_DEF,
   parameter int unsigned MAX_RETRY   = MAX_RETRY_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input logic                  CLK100MHZ,
   input logic                  CPU_RESETN,
   motor_oc_supervisor_if.slave bus
);

   localparam logic [CNT_W-1:0]   QUAL_LAST = CNT_W'(QUAL_CYCLES - 1);
   localparam logic [CNT_W-1:0]   COOL_LAST = CNT_W'(COOL_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   oc_state_t          state_q, state_d;
   logic [1:0]         sync_a_q, sync_b_q;
   logic               en_a_q, en_a_d, en_b_q, en_b_d;
   logic               oc_q, oc_d, lock_q, lock_d;
   logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
`ifdef OC_CAUSE_EN
   logic [1:0]         cause_q, cause_d;
`endif

   tmr_cmd_t           tmr_cmd;
   logic [CNT_W-1:0]   tmr_load, tmr_cnt;
   logic               tmr_zero;
   logic               oc;

   oc_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (CLK100MHZ),
      .rst_n      (CPU_RESETN),
      .cmd_i      (tmr_cmd),
      .load_val_i (tmr_load),
      .cnt_o      (tmr_cnt),
      .zero_o     (tmr_zero)
   );

   // Sense pins are active-low and asynchronous; flops idle high so reset reads as healthy.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         sync_a_q <= 2'b11;
         sync_b_q <= 2'b11;
      end else begin
         sync_a_q <= {sync_a_q[0], bus.OCA};
         sync_b_q <= {sync_b_q[0], bus.OCB};
      end
   end

   assign oc        = ~sync_a_q[1] | ~sync_b_q[1];
   assign retry_inc = (retry_q == '1) ? retry_q : retry_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      tmr_cmd  = TMR_HOLD;
      tmr_load = '0;
      retry_d  = retry_q;
`ifdef OC_CAUSE_EN
      cause_d  = cause_q;
`endif
      case (state_q)
         RUN: begin
            if (oc) begin
               state_d  = QUAL;
               tmr_cmd  = TMR_LOAD;
               tmr_load = QUAL_LAST;
            end else if (tmr_cnt == COOL_LAST) begin
               // A full healthy window forgives earlier trips; timer parks here.
               retry_d = '0;
            end else begin
               tmr_cmd = TMR_INC;
            end
         end
         QUAL: begin
            // A drop wins over an expiring timer: glitch rejected.
            if (!oc) begin
               state_d = RUN;
               tmr_cmd = TMR_CLR;
            end else if (tmr_zero) begin
               state_d = TRIP;
               retry_d = retry_inc;
`ifdef OC_CAUSE_EN
               cause_d = {~sync_b_q[1], ~sync_a_q[1]};
`endif
            end else begin
               tmr_cmd = TMR_DEC;
            end
         end
         TRIP: begin
            // retry_q already holds the incremented count here.
            if (retry_q >= RETRY_MAX) begin
               state_d = LOCKOUT;
            end else begin
               state_d  = COOL;
               tmr_cmd  = TMR_LOAD;
               tmr_load = COOL_LAST;
            end
         end
         COOL: begin
            if (tmr_zero) begin
               state_d = RUN;
               tmr_cmd = TMR_CLR;
            end else begin
               tmr_cmd = TMR_DEC;
            end
         end
         LOCKOUT: begin
            if (bus.fault_clr && !oc) begin
               state_d = RUN;
               tmr_cmd = TMR_CLR;
               retry_d = '0;
`ifdef OC_CAUSE_EN
               cause_d = 2'b00;
`endif
            end
         end
         default: begin
            state_d = RUN;
            tmr_cmd = TMR_CLR;
         end
      endcase
   end

   // Outputs are decoded from the next state so they move on the same edge as the state.
   always_comb begin
      en_a_d = ((state_d == RUN) || (state_d == QUAL)) && bus.req_a;
      en_b_d = ((state_d == RUN) || (state_d == QUAL)) && bus.req_b;
      oc_d   = (state_d == TRIP) || (state_d == COOL) || (state_d == LOCKOUT);
      lock_d = (state_d == LOCKOUT);
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_q <= RUN;
         en_a_q  <= 1'b0;
         en_b_q  <= 1'b0;
         oc_q    <= 1'b0;
         lock_q  <= 1'b0;
         retry_q <= '0;
`ifdef OC_CAUSE_EN
         cause_q <= 2'b00;
`endif
      end else begin
         state_q <= state_d;
         en_a_q  <= en_a_d;
         en_b_q  <= en_b_d;
         oc_q    <= oc_d;
         lock_q  <= lock_d;
         retry_q <= retry_d;
`ifdef OC_CAUSE_EN
         cause_q <= cause_d;
`endif
      end
   end

   assign bus.ENA         = en_a_q;
   assign bus.ENB         = en_b_q;
   assign bus.overcurrent = oc_q;
   assign bus.lockout     = lock_q;
   assign bus.retry_cnt   = retry_q;
`ifdef OC_CAUSE_EN
   assign bus.oc_cause    = cause_q;
`endif

endmodule
